uart_rx_mode1: RTL and testbench

Receive half of the 8051-compatible Mode 1 UART: 10-bit frame (start, 8 data bits LSB first, stop) at a variable baud rate set by the timer-derived 16x sample tick. Synchronises the asynchronous `rx` pin and majority-votes each bit. Applies the 8051 Mode 1 load rules (RI/SM2/RB8), then delivers the byte to the SBUF model with an RI flag. It pairs with the Mode 1 transmitter, and both hang off the same baud tick generator.

---
 rtl/uart_rx_mode1.sv | 121 ++++++++++++
 tb/tb_uart_rx_mode1.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mode1.sv
// uart_rx_mode1: 8051 Mode 1 UART receiver with 16x oversampling, 3-sample majority vote and RI/SM2/RB8 load rules
module uart_rx_mode1 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       tick_16x_i,
    input  logic       ren_i,
    input  logic       sm2_i,
    input  logic       ri_clr_i,
    output logic [7:0] rx_data_o,
    output logic       rb8_o,
    output logic       ri_o,
    output logic       rx_busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t     state_q, state_d;
    logic       sync_q, rxs_q, prev_q;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bit_q, bit_d;
    logic       s7_q, s7_d, s8_q, s8_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       rb8_q, rb8_d, ri_q, ri_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic       start_det, vote_tick, end_tick, vote, load;
    assign start_det   = state_q == IDLE && ren_i && prev_q && !rxs_q;
    assign vote_tick   = tick_16x_i && scnt_q == 4'd9;
    assign end_tick    = tick_16x_i && scnt_q == 4'd15;
    assign vote        = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    assign load        = state_q == STOP && vote_tick && !ri_q && (!sm2_i || vote);
    assign rx_data_o   = data_q;
    assign rb8_o       = rb8_q;
    assign ri_o        = ri_q;
    assign rx_busy_o   = state_q != IDLE;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    // Next-state: frame sequencing, sample counting, voting and the SBUF load rule
    always_comb begin
        state_d = state_q;
        scnt_d  = (state_q != IDLE && tick_16x_i) ? scnt_q + 4'd1 : scnt_q;
        bit_d   = bit_q;
        s7_d    = (tick_16x_i && scnt_q == 4'd7) ? rxs_q : s7_q;
        s8_d    = (tick_16x_i && scnt_q == 4'd8) ? rxs_q : s8_q;
        shift_d = shift_q;
        data_d  = data_q;
        rb8_d   = rb8_q;
        ri_d    = ri_clr_i ? 1'b0 : ri_q;
        ferr_d  = ri_clr_i ? 1'b0 : ferr_q;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d = START;
                    scnt_d  = 4'd0;
                end
            end
            START: begin
                if (vote_tick && vote) begin
                    state_d = IDLE;
                end else if (end_tick) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (vote_tick) shift_d = {vote, shift_q[7:1]};
                if (end_tick) begin
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (vote_tick) begin
                    state_d = IDLE;
                    ovr_d   = !load && ri_q;
                    if (load) begin
                        data_d = shift_q;
                        rb8_d  = vote;
                        ri_d   = 1'b1;
                        ferr_d = !vote;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers, including the two-flop synchroniser and edge register on rx
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            scnt_q  <= 4'd0;
            bit_q   <= 3'd0;
            s7_q    <= 1'b0;
            s8_q    <= 1'b0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            rb8_q   <= 1'b0;
            ri_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= rx_i;
            rxs_q   <= sync_q;
            prev_q  <= rxs_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bit_q   <= bit_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rb8_q   <= rb8_d;
            ri_q    <= ri_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_mode1.sv
// tb_uart_rx_mode1: scenario tasks with a scoreboard of expected SBUF loads for uart_rx_mode1
module tb_uart_rx_mode1;
    logic       clk = 1'b0;
    logic       rst, rx, tick, ren, sm2, ri_clr;
    logic [7:0] rx_data;
    logic       rb8, ri, rx_busy, frame_err, overrun;
    int         cyc = 0;
    int         ovr_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    typedef struct packed {
        logic [7:0] d;
        logic       rb8;
        logic       ferr;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    uart_rx_mode1 dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .tick_16x_i(tick), .ren_i(ren), .sm2_i(sm2),
        .ri_clr_i(ri_clr), .rx_data_o(rx_data), .rb8_o(rb8), .ri_o(ri), .rx_busy_o(rx_busy),
        .frame_err_o(frame_err), .overrun_o(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

    // One-clk tick every 4 clk, asserted on negedges where cyc is a multiple of 4
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (cyc % 4 == 0);
        end
    end

    function automatic exp_t pop_exp();
        exp_t x;
        x = 'x;
        if (sbq.size() != 0) x = sbq.pop_front();
        return x;
    endfunction

    // Frame bit j occupies 64 clk; samples 7/8/9 see rx at clk 31/35/39 of the bit, stop vote at clk 41 of bit 9
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit, input int gpos,
                              input logic clr_coll, input int rst_bit);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        do @(negedge clk); while (cyc % 4 != 0);
        for (int j = 0; j < 10; j++) begin
            for (int c = 1; c <= 64; c++) begin
                if (j != 0 || c != 1) @(negedge clk);
                rx = (j == gbit && c == gpos) ? ~f[j] : f[j];
                if (clr_coll) ri_clr = (j == 9 && c == 41);
                if (rst_bit >= 0) rst = (j == rst_bit && c == 32);
            end
        end
        @(negedge clk);
        rx = 1'b1;
        ri_clr = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ri_clr = 1'b1;
        @(negedge clk);
        ri_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_checks += 6;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h expected 00", rx_data); end
        if (rb8 !== 1'b0) begin n_fail++; $display("FAIL reset_rb8: got %b expected 0", rb8); end
        if (ri !== 1'b0) begin n_fail++; $display("FAIL reset_ri: got %b expected 0", ri); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_basic();
        sbq.push_back('{8'hA5, 1'b1, 1'b0});
        send_frame(8'hA5, 1'b1, -1, 0, 1'b0, -1);
        e = pop_exp();
        n_checks += 5;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL basic_data: got %02h expected %02h", rx_data, e.d); end
        if (rb8 !== e.rb8) begin n_fail++; $display("FAIL basic_rb8: got %b expected %b", rb8, e.rb8); end
        if (ri !== 1'b1) begin n_fail++; $display("FAIL basic_ri: got %b expected 1", ri); end
        if (frame_err !== e.ferr) begin n_fail++; $display("FAIL basic_ferr: got %b expected %b", frame_err, e.ferr); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", rx_busy); end
        pulse_clr();
        n_checks++;
        if (ri !== 1'b0) begin n_fail++; $display("FAIL basic_clr: ri got %b expected 0", ri); end
    endtask

    task automatic test_overrun();
        int o0;
        sbq.push_back('{8'h3C, 1'b1, 1'b0});
        send_frame(8'h3C, 1'b1, -1, 0, 1'b0, -1);
        e = pop_exp();
        n_checks++;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL ovr_first: got %02h expected %02h", rx_data, e.d); end
        o0 = ovr_cnt;
        send_frame(8'hC3, 1'b1, -1, 0, 1'b0, -1);
        n_checks += 3;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL ovr_keep: got %02h expected %02h", rx_data, e.d); end
        if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - o0); end
        if (ri !== 1'b1) begin n_fail++; $display("FAIL ovr_ri: got %b expected 1", ri); end
        pulse_clr();
        n_checks++;
        if (ri !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: ri got %b expected 0", ri); end
    endtask

    task automatic test_multiproc();
        sm2 = 1'b1;
        send_frame(8'h55, 1'b0, -1, 0, 1'b0, -1);
        n_checks += 2;
        if (ri !== 1'b0) begin n_fail++; $display("FAIL mp_noload_ri: got %b expected 0", ri); end
        if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL mp_noload_data: got %02h expected 3c", rx_data); end
        sbq.push_back('{8'h55, 1'b1, 1'b0});
        send_frame(8'h55, 1'b1, -1, 0, 1'b0, -1);
        e = pop_exp();
        n_checks += 3;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL mp_data: got %02h expected %02h", rx_data, e.d); end
        if (rb8 !== e.rb8) begin n_fail++; $display("FAIL mp_rb8: got %b expected %b", rb8, e.rb8); end
        if (ri !== 1'b1) begin n_fail++; $display("FAIL mp_ri: got %b expected 1", ri); end
        sm2 = 1'b0;
        pulse_clr();
    endtask

    task automatic test_false_start_glitch();
        do @(negedge clk); while (cyc % 4 != 0);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL fs_busy_start: got %b expected 1", rx_busy); end
        repeat (80) @(negedge clk);
        n_checks += 2;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL fs_busy_end: got %b expected 0", rx_busy); end
        if (ri !== 1'b0) begin n_fail++; $display("FAIL fs_ri: got %b expected 0", ri); end
        sbq.push_back('{8'h0F, 1'b1, 1'b0});
        send_frame(8'h0F, 1'b1, 3, 35, 1'b0, -1);
        e = pop_exp();
        n_checks += 2;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL glitch_data: got %02h expected %02h", rx_data, e.d); end
        if (ri !== 1'b1) begin n_fail++; $display("FAIL glitch_ri: got %b expected 1", ri); end
        pulse_clr();
    endtask

    task automatic test_framing_collision();
        sbq.push_back('{8'h81, 1'b0, 1'b1});
        send_frame(8'h81, 1'b0, -1, 0, 1'b0, -1);
        e = pop_exp();
        n_checks += 4;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL fe_data: got %02h expected %02h", rx_data, e.d); end
        if (ri !== 1'b1) begin n_fail++; $display("FAIL fe_ri: got %b expected 1", ri); end
        if (frame_err !== e.ferr) begin n_fail++; $display("FAIL fe_ferr: got %b expected %b", frame_err, e.ferr); end
        if (rb8 !== e.rb8) begin n_fail++; $display("FAIL fe_rb8: got %b expected %b", rb8, e.rb8); end
        pulse_clr();
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL fe_clr: got %b expected 0", frame_err); end
        sbq.push_back('{8'h7E, 1'b1, 1'b0});
        send_frame(8'h7E, 1'b1, -1, 0, 1'b1, -1);
        e = pop_exp();
        n_checks += 2;
        if (ri !== 1'b1) begin n_fail++; $display("FAIL coll_ri: got %b expected 1", ri); end
        if (rx_data !== e.d) begin n_fail++; $display("FAIL coll_data: got %02h expected %02h", rx_data, e.d); end
        pulse_clr();
    endtask

    task automatic test_reset_enable();
        send_frame(8'hFF, 1'b1, -1, 0, 1'b0, 5);
        n_checks += 4;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mrst_data: got %02h expected 00", rx_data); end
        if (rb8 !== 1'b0) begin n_fail++; $display("FAIL mrst_rb8: got %b expected 0", rb8); end
        if (ri !== 1'b0) begin n_fail++; $display("FAIL mrst_ri: got %b expected 0", ri); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b expected 0", rx_busy); end
        sbq.push_back('{8'h12, 1'b1, 1'b0});
        send_frame(8'h12, 1'b1, -1, 0, 1'b0, -1);
        e = pop_exp();
        n_checks++;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL mrst_next: got %02h expected %02h", rx_data, e.d); end
        pulse_clr();
        ren = 1'b0;
        send_frame(8'h99, 1'b1, -1, 0, 1'b0, -1);
        n_checks += 2;
        if (ri !== 1'b0) begin n_fail++; $display("FAIL ren0_ri: got %b expected 0", ri); end
        if (rx_data !== 8'h12) begin n_fail++; $display("FAIL ren0_data: got %02h expected 12", rx_data); end
        ren = 1'b1;
        sbq.push_back('{8'h6B, 1'b1, 1'b0});
        fork
            send_frame(8'h6B, 1'b1, -1, 0, 1'b0, -1);
            begin
                repeat (200) @(negedge clk);
                ren = 1'b0;
            end
        join
        ren = 1'b1;
        e = pop_exp();
        n_checks += 2;
        if (rx_data !== e.d) begin n_fail++; $display("FAIL rendrop_data: got %02h expected %02h", rx_data, e.d); end
        if (ri !== 1'b1) begin n_fail++; $display("FAIL rendrop_ri: got %b expected 1", ri); end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        ren = 1'b1;
        sm2 = 1'b0;
        ri_clr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        test_basic();
        test_overrun();
        test_multiproc();
        test_false_start_glitch();
        test_framing_collision();
        test_reset_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
